// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack, holds the word
// on I until the datapath retires it, then selects the sequential/branch/jump next PC.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] COUNT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] I,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    input  logic        inst_taken,
    input  logic        branch_taken,
    input  logic        jump,
    output logic [31:0] inst_count,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] count_q;
    logic [31:0] pc_plus4_d;
    logic [31:0] next_pc_d;
    logic [31:0] count_d;

    // Memory handshake: imem_req is held with a constant imem_addr until the
    // single-cycle imem_ack pulse; an ack seen outside REQ is ignored.
    always_comb begin
        pc_plus4_d = pc_q + 32'd4;
        count_d    = count_q + 32'd1;
        next_pc_d  = pc_plus4_d;
        if (jump) begin
            next_pc_d = {pc_plus4_d[31:28], inst_q[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc_d = pc_plus4_d + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0000_0000;
            count_q <= COUNT_RESET;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        inst_q  <= imem_rdata;
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (inst_taken) begin
                        pc_q    <= next_pc_d;
                        count_q <= count_d;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign I           = inst_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_d;
    assign inst_valid  = valid_q;
    assign inst_count  = count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: three instances (base, wrap, high-PC) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_instruction_fetch;

    localparam int N = 3;
    localparam int PH_IDLE = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_HOLD = 2;

    logic              clk = 1'b0;
    logic [N-1:0]      rst_v = '1;
    logic [N-1:0]      ack_v = '0;
    logic [N-1:0]      taken_v = '0;
    logic [N-1:0]      br_v = '0;
    logic [N-1:0]      jmp_v = '0;
    logic [31:0]       rdata_v [N];
    logic [N-1:0]      req_w;
    logic [N-1:0]      valid_w;
    logic [31:0]       addr_w [N];
    logic [31:0]       i_w [N];
    logic [31:0]       pc_w [N];
    logic [31:0]       pc4_w [N];
    logic [31:0]       cnt_w [N];
    logic [1:0]        dbg_w [N];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    int          m_ph [N];
    logic        m_init [N];
    logic [31:0] m_pc [N];
    logic [31:0] m_i [N];
    logic [31:0] m_cnt [N];
    logic        prev_req0 = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        instruction_fetch #(
            .RESET_PC   (g == 0 ? 32'h0000_0000 : (g == 1 ? 32'hFFFF_FFFC : 32'h4000_0010)),
            .COUNT_RESET(g == 1 ? 32'hFFFF_FFFE : 32'h0000_0000)
        ) u_dut (
            .clk         (clk),
            .rst         (rst_v[g]),
            .imem_req    (req_w[g]),
            .imem_addr   (addr_w[g]),
            .imem_ack    (ack_v[g]),
            .imem_rdata  (rdata_v[g]),
            .I           (i_w[g]),
            .pc          (pc_w[g]),
            .pc_plus4    (pc4_w[g]),
            .inst_valid  (valid_w[g]),
            .inst_taken  (taken_v[g]),
            .branch_taken(br_v[g]),
            .jump        (jmp_v[g]),
            .inst_count  (cnt_w[g]),
            .dbg_state_o (dbg_w[g])
        );
    end

    function automatic logic [31:0] rpc(int k);
        return (k == 0) ? 32'h0000_0000 : ((k == 1) ? 32'hFFFF_FFFC : 32'h4000_0010);
    endfunction

    function automatic logic [31:0] cnt0(int k);
        return (k == 1) ? 32'hFFFF_FFFE : 32'h0000_0000;
    endfunction

    // Next address straight from the ISA rules, using signed integer arithmetic.
    function automatic logic [31:0] model_next(logic [31:0] cur, logic [31:0] ins, logic b, logic j);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(ins[15:0]));
        if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (b) return seq + 32'(4 * off);
        return seq;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: at each edge apply reset / accept ack / retire according to the ISA rules.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst_v[k]) begin
                m_init[k] <= 1'b1;
                m_ph[k]   <= PH_IDLE;
                m_pc[k]   <= rpc(k);
                m_i[k]    <= 32'h0;
                m_cnt[k]  <= cnt0(k);
                if (k == 0) begin
                    exp_q.delete();
                    exp_q.push_back(rpc(0));
                end
            end else if (m_ph[k] == PH_IDLE) begin
                m_ph[k] <= PH_FETCH;
            end else if (m_ph[k] == PH_FETCH && ack_v[k]) begin
                m_i[k]  <= rdata_v[k];
                m_ph[k] <= PH_HOLD;
            end else if (m_ph[k] == PH_HOLD && taken_v[k]) begin
                m_pc[k]  <= model_next(m_pc[k], m_i[k], br_v[k], jmp_v[k]);
                m_cnt[k] <= m_cnt[k] + 32'd1;
                m_ph[k]  <= PH_FETCH;
                if (k == 0) exp_q.push_back(model_next(m_pc[k], m_i[k], br_v[k], jmp_v[k]));
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (m_init[k] === 1'b1) begin
                check("cyc_req", {31'b0, req_w[k]}, {31'b0, m_ph[k] == PH_FETCH});
                check("cyc_valid", {31'b0, valid_w[k]}, {31'b0, m_ph[k] == PH_HOLD});
                check("cyc_addr", addr_w[k], m_pc[k]);
                check("cyc_pc", pc_w[k], m_pc[k]);
                check("cyc_pc4", pc4_w[k], m_pc[k] + 32'd4);
                check("cyc_I", i_w[k], m_i[k]);
                check("cyc_count", cnt_w[k], m_cnt[k]);
            end
        end
        if (req_w[0] && !prev_req0) begin
            if (exp_q.size() == 0) begin
                check("sb_addr_queue_empty", 32'd0, 32'd1);
            end else begin
                check("sb_fetch_addr", addr_w[0], exp_q.pop_front());
            end
        end
        prev_req0 <= req_w[0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int k, input int delay, input logic [31:0] word);
        for (int c = 0; c < 50 && !req_w[k]; c++) tick();
        if (!req_w[k]) begin
            check("timeout_req", 32'd0, 32'd1);
        end else begin
            for (int d = 0; d < delay; d++) tick();
            ack_v[k]   = 1'b1;
            rdata_v[k] = word;
            tick();
            ack_v[k]   = 1'b0;
        end
    endtask

    task automatic retire(input int k, input logic b, input logic j);
        for (int c = 0; c < 50 && !valid_w[k]; c++) tick();
        if (!valid_w[k]) begin
            check("timeout_valid", 32'd0, 32'd1);
        end else begin
            taken_v[k] = 1'b1;
            br_v[k]    = b;
            jmp_v[k]   = j;
            tick();
            taken_v[k] = 1'b0;
            br_v[k]    = 1'b0;
            jmp_v[k]   = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rdata_v[k] = 32'h0;
            m_init[k]  = 1'b0;
        end
        tick();
        rst_v = '0;
        check("rst_pc", pc_w[0], 32'h0);
        check("rst_pc4", pc4_w[0], 32'h4);
        check("rst_I", i_w[0], 32'h0);
        check("rst_valid", {31'b0, valid_w[0]}, 32'd0);
        check("rst_req", {31'b0, req_w[0]}, 32'd0);
        check("rst_addr", addr_w[0], 32'h0);
        check("rst_count", cnt_w[0], 32'h0);
        check("rst_pc4_wrap", pc4_w[1], 32'h0);
        tick();
        check("first_req", {31'b0, req_w[0]}, 32'd1);

        fetch(0, 0, 32'h0000_0000);
        check("I_nop", i_w[0], 32'h0);
        check("valid_after_ack", {31'b0, valid_w[0]}, 32'd1);
        retire(0, 1'b0, 1'b0);
        check("seq_addr_4", addr_w[0], 32'h4);
        fetch(0, 3, 32'h2408_0001);
        check("I_addiu", i_w[0], 32'h2408_0001);
        retire(0, 1'b0, 1'b0);
        check("seq_addr_8", addr_w[0], 32'h8);
        fetch(0, 1, 32'h0800_0040);
        retire(0, 1'b0, 1'b1);
        check("count_3", cnt_w[0], 32'd3);
        check("jump_0x100", addr_w[0], 32'h100);

        fetch(0, 0, 32'h1000_FFFE);
        ack_v[0] = 1'b1;
        rdata_v[0] = 32'hFFFF_FFFF;
        tick();
        ack_v[0] = 1'b0;
        check("spurious_ack_I", i_w[0], 32'h1000_FFFE);
        retire(0, 1'b1, 1'b0);
        check("branch_taken_FC", addr_w[0], 32'hFC);
        taken_v[0] = 1'b1;
        tick();
        taken_v[0] = 1'b0;
        check("spurious_taken_pc", pc_w[0], 32'hFC);
        check("spurious_taken_cnt", cnt_w[0], 32'd4);
        fetch(0, 2, 32'h0800_0040);
        retire(0, 1'b0, 1'b1);
        fetch(0, 0, 32'h1000_FFFE);
        retire(0, 1'b0, 1'b0);
        check("branch_not_taken", addr_w[0], 32'h104);

        for (int c = 0; c < 50 && !req_w[0]; c++) tick();
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        check("rst_in_req_drops_req", {31'b0, req_w[0]}, 32'd0);
        ack_v[0] = 1'b1;
        rdata_v[0] = 32'hDEAD_BEEF;
        tick();
        ack_v[0] = 1'b0;
        check("late_ack_I", i_w[0], 32'h0);
        check("restart_addr", addr_w[0], 32'h0);
        fetch(0, 0, 32'h2108_0004);
        rst_v[0] = 1'b1;
        taken_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        taken_v[0] = 1'b0;
        check("rst_hold_count", cnt_w[0], 32'd0);
        check("rst_hold_I", i_w[0], 32'd0);

        fetch(2, 0, 32'h0800_0040);
        retire(2, 1'b0, 1'b1);
        check("jump_high", pc_w[2], 32'h4000_0100);
        fetch(2, 1, 32'h0800_0080);
        retire(2, 1'b1, 1'b1);
        check("jump_beats_branch", addr_w[2], 32'h4000_0200);

        fetch(1, 0, 32'h0000_0000);
        retire(1, 1'b0, 1'b0);
        check("pc_wrap", addr_w[1], 32'h0);
        check("count_ffff", cnt_w[1], 32'hFFFF_FFFF);
        fetch(1, 0, 32'h0000_0000);
        retire(1, 1'b0, 1'b0);
        check("count_wrap", cnt_w[1], 32'h0);
        fetch(1, 0, 32'h1000_FFFD);
        retire(1, 1'b1, 1'b0);
        check("branch_wrap", addr_w[1], 32'hFFFF_FFFC);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
